// File: rtl/inst_cache.sv
// Direct-mapped, one-word-per-line instruction cache between fetch and the memory controller.
// Hits return the word the cycle after the request; misses fill the line and forward the word.
module inst_cache #(
    parameter int INDEX_BITS = 6,
    parameter int ADDR_BITS  = 18
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    input  logic        if_flush,
    output logic        if_ready,
    output logic        if_valid,
    output logic [31:0] if_data,
    output logic        inst_re,
    output logic [31:0] inst_addr,
    input  logic [31:0] inst_data,
    input  logic        inst_busy
);
    localparam int LINES = 2 ** INDEX_BITS;
    localparam int TAG_W = ADDR_BITS - INDEX_BITS - 2;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;
    state_t state_q, state_d;

    logic [LINES-1:0] valid_q;
    logic [TAG_W-1:0] tag_q  [LINES];
    logic [31:0]      data_q [LINES];
    logic             drop_q;

    logic [INDEX_BITS-1:0] req_idx, fill_idx;
    logic [TAG_W-1:0]      req_tag, fill_tag;
    logic                  hit, accept, fill;
    logic                  unused_addr_bits;

    assign req_idx  = if_addr[INDEX_BITS+1:2];
    assign req_tag  = if_addr[ADDR_BITS-1:INDEX_BITS+2];
    // The fill targets the line named by the latched miss address, not the live fetch address.
    assign fill_idx = inst_addr[INDEX_BITS+1:2];
    assign fill_tag = inst_addr[ADDR_BITS-1:INDEX_BITS+2];

    assign hit      = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
    assign accept   = (state_q == S_IDLE) && if_req && !if_flush;
    assign fill     = rdy && (state_q == S_WAIT) && !inst_busy;
    assign if_ready = (state_q == S_IDLE);

    assign unused_addr_bits = ^if_addr[1:0];

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept && !hit) state_d = S_REQ;
            S_REQ:   if (inst_busy)      state_d = S_WAIT;
            S_WAIT:  if (!inst_busy)     state_d = S_IDLE;
            default:                     state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state_q <= S_IDLE;
        else if (rdy)
            state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q   <= '0;
            if_valid  <= 1'b0;
            if_data   <= '0;
            inst_re   <= 1'b0;
            inst_addr <= '0;
            drop_q    <= 1'b0;
        end else if (rdy) begin
            if_valid <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        if (hit) begin
                            if_valid <= 1'b1;
                            if_data  <= data_q[req_idx];
                        end else begin
                            inst_re   <= 1'b1;
                            inst_addr <= {if_addr[31:2], 2'b00};
                        end
                    end
                end
                S_REQ: begin
                    if (if_flush)  drop_q  <= 1'b1;
                    if (inst_busy) inst_re <= 1'b0;
                end
                S_WAIT: begin
                    if (if_flush) drop_q <= 1'b1;
                    // A redirected fetch still gets its line written, just not forwarded.
                    if (!inst_busy) begin
                        valid_q[fill_idx] <= 1'b1;
                        drop_q            <= 1'b0;
                        if (!(drop_q || if_flush)) begin
                            if_valid <= 1'b1;
                            if_data  <= inst_data;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (fill) begin
            tag_q[fill_idx]  <= fill_tag;
            data_q[fill_idx] <= inst_data;
        end
    end

endmodule

// File: tb/tb_inst_cache.sv
// Bench for inst_cache: a behavioural controller plus an address-level cache model
// checked against directed scenarios and randomized fetch sequences.
module tb_inst_cache;
    localparam int INDEX_BITS = 6;
    localparam int ADDR_BITS  = 18;
    localparam int LINES      = 2 ** INDEX_BITS;

    logic        clk = 1'b0;
    logic        rst, rdy, if_req, if_flush, inst_busy;
    logic [31:0] if_addr, inst_data;
    logic        if_ready, if_valid, inst_re;
    logic [31:0] if_data, inst_addr;

    int n_tests = 0;
    int n_fail  = 0;

    int ctrl_delay    = 2;
    int ctrl_busy_len = 2;
    bit ctrl_active   = 0;

    // Reference model: which word address each line currently holds.
    bit          ref_valid [LINES];
    logic [31:0] ref_addr  [LINES];

    inst_cache #(.INDEX_BITS(INDEX_BITS), .ADDR_BITS(ADDR_BITS)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_ready(if_ready), .if_valid(if_valid), .if_data(if_data),
        .inst_re(inst_re), .inst_addr(inst_addr),
        .inst_data(inst_data), .inst_busy(inst_busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0000_0100) return 32'h0000_0013;
        return {a[15:0] ^ 16'h5a5a, a[31:16] ^ 16'h1234};
    endfunction

    function automatic int line_of(input logic [31:0] a);
        return int'(a[INDEX_BITS+1:2]);
    endfunction

    // Only the low ADDR_BITS address bits distinguish lines.
    function automatic bit model_hit(input logic [31:0] a);
        int i = line_of(a);
        return ref_valid[i] && (ref_addr[i][ADDR_BITS-1:2] == a[ADDR_BITS-1:2]);
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < LINES; i++) ref_valid[i] = 0;
    endfunction

    // Controller: after inst_re, idle ctrl_delay cycles, busy ctrl_busy_len cycles, then data.
    initial begin : controller
        logic [31:0] a;
        inst_busy = 1'b0;
        inst_data = '0;
        forever begin
            @(posedge clk); #1;
            if (inst_re === 1'b1 && rst === 1'b1) begin
                ctrl_active = 1;
                a = inst_addr;
                repeat (ctrl_delay) @(posedge clk);
                #1 inst_busy = 1'b1;
                repeat (ctrl_busy_len) @(posedge clk);
                #1 inst_busy = 1'b0;
                inst_data = mem_word(a);
                @(posedge clk); #1;
                inst_data = '0;
                ctrl_active = 0;
            end
        end
    end

    task automatic wait_ready();
        int c = 0;
        while ((if_ready !== 1'b1 || ctrl_active) && c < 200) begin
            @(posedge clk); #1;
            c++;
        end
        n_tests++;
        if (if_ready !== 1'b1 || ctrl_active) begin
            n_fail++;
            $display("FAIL wait_ready: if_ready=%b required 1", if_ready);
        end
    endtask

    // exp_hit: 1/0 forces the expected outcome, -1 takes it from the model.
    task automatic do_fetch(input logic [31:0] addr, input int exp_hit);
        bit          h, got, seen_busy;
        logic [31:0] al, w;
        int          cyc;
        wait_ready();
        al = {addr[31:2], 2'b00};
        h  = (exp_hit < 0) ? model_hit(addr) : (exp_hit != 0);
        w  = h ? mem_word(ref_addr[line_of(addr)]) : mem_word(al);
        if_req = 1'b1;
        if_addr = addr;
        @(posedge clk); #1;
        if_req = 1'b0;
        if_addr = $urandom;
        n_tests++;
        if (if_valid !== h) begin
            n_fail++;
            $display("FAIL fetch_hit %h: if_valid=%b required %b", addr, if_valid, h);
        end
        if (h) begin
            n_tests++;
            if (if_data !== w || inst_re !== 1'b0) begin
                n_fail++;
                $display("FAIL hit_data %h: data=%h re=%b required %h re=0", addr, if_data, inst_re, w);
            end
        end else begin
            n_tests++;
            if (inst_re !== 1'b1 || inst_addr !== al) begin
                n_fail++;
                $display("FAIL miss_req %h: re=%b addr=%h required re=1 addr=%h", addr, inst_re, inst_addr, al);
            end
            got = 0;
            cyc = 0;
            @(negedge clk);
            seen_busy = inst_busy;
            while (!got && cyc < 300) begin
                @(posedge clk); #1;
                cyc++;
                if (if_valid === 1'b1) begin
                    got = 1;
                    n_tests++;
                    if (if_data !== w) begin
                        n_fail++;
                        $display("FAIL fill_data %h: got %h required %h", addr, if_data, w);
                    end
                end else begin
                    n_tests++;
                    if (if_ready !== 1'b0 || (!seen_busy && inst_re !== 1'b1)) begin
                        n_fail++;
                        $display("FAIL miss_wait %h: ready=%b re=%b required ready=0 re=%b", addr, if_ready, inst_re, !seen_busy);
                    end
                end
                @(negedge clk);
                seen_busy |= inst_busy;
            end
            @(posedge clk); #1;
            n_tests++;
            if (!got || if_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL fill_pulse %h: seen=%b if_valid_after=%b required seen=1 after=0", addr, got, if_valid);
            end
            ref_valid[line_of(addr)] = 1;
            ref_addr[line_of(addr)] = al;
        end
    endtask

    task automatic wait_in_wait(input string name);
        int c = 0;
        while (!(inst_re === 1'b0 && inst_busy === 1'b1) && c < 100) begin
            @(posedge clk); #1;
            c++;
        end
        n_tests++;
        if (!(inst_re === 1'b0 && inst_busy === 1'b1)) begin
            n_fail++;
            $display("FAIL %s: re=%b busy=%b required re=0 busy=1", name, inst_re, inst_busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; rdy = 1'b1; if_req = 1'b0; if_flush = 1'b0; if_addr = '0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if (if_valid !== 1'b0 || if_data !== 32'h0 || inst_re !== 1'b0 || inst_addr !== 32'h0 || if_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_state: v=%b d=%h re=%b a=%h rdy=%b required 0/0/0/0/1", if_valid, if_data, inst_re, inst_addr, if_ready);
        end
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_cold_miss();
        do_fetch(32'h100, 0);
    endtask

    task automatic test_hit();
        do_fetch(32'h100, 1);
        do_fetch(32'h102, 1);
    endtask

    task automatic test_conflict();
        do_fetch(32'h200, 0);
        do_fetch(32'h100, 0);
    endtask

    task automatic test_ctrl_delay();
        ctrl_delay = 10;
        do_fetch(32'h500, 0);
        ctrl_delay = 2;
        do_fetch(32'h500, 1);
    endtask

    task automatic test_flush();
        int c = 0;
        ctrl_busy_len = 3;
        wait_ready();
        if_req = 1'b1; if_addr = 32'h300;
        @(posedge clk); #1;
        if_req = 1'b0;
        n_tests++;
        if (inst_re !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_miss: inst_re=%b required 1", inst_re);
        end
        wait_in_wait("flush_reach_wait");
        if_flush = 1'b1;
        @(posedge clk); #1;
        if_flush = 1'b0;
        do begin
            n_tests++;
            if (if_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL flush_drop: if_valid=%b required 0", if_valid);
            end
            @(posedge clk); #1;
            c++;
        end while (if_ready !== 1'b1 && c < 100);
        n_tests++;
        if (if_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_drop_end: if_valid=%b required 0", if_valid);
        end
        ctrl_busy_len = 2;
        ref_valid[line_of(32'h300)] = 1;
        ref_addr[line_of(32'h300)] = 32'h300;
        do_fetch(32'h300, 1);
    endtask

    task automatic test_back_to_back();
        logic [31:0] a [4];
        a[0] = 32'h10; a[1] = 32'h14; a[2] = 32'h18; a[3] = 32'h1c;
        for (int i = 0; i < 4; i++) do_fetch(a[i], 0);
        wait_ready();
        if_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if_addr = a[i];
            @(posedge clk); #1;
            n_tests++;
            if (if_valid !== 1'b1 || if_data !== mem_word(a[i]) || inst_re !== 1'b0) begin
                n_fail++;
                $display("FAIL b2b_hit %0d: v=%b d=%h re=%b required v=1 d=%h re=0", i, if_valid, if_data, inst_re, mem_word(a[i]));
            end
        end
        if_req = 1'b0;
    endtask

    task automatic test_reset_mid_wait();
        ctrl_busy_len = 3;
        wait_ready();
        if_req = 1'b1; if_addr = 32'h400;
        @(posedge clk); #1;
        if_req = 1'b0;
        wait_in_wait("reset_reach_wait");
        #2 rst = 1'b0;
        #1;
        n_tests++;
        if (if_valid !== 1'b0 || if_data !== 32'h0 || inst_re !== 1'b0 || inst_addr !== 32'h0) begin
            n_fail++;
            $display("FAIL async_reset: v=%b d=%h re=%b a=%h required all 0", if_valid, if_data, inst_re, inst_addr);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        model_clear();
        ctrl_busy_len = 2;
        do_fetch(32'h400, 0);
        do_fetch(32'h100, 0);
    endtask

    task automatic test_rdy_freeze();
        do_fetch(32'h100, 1);
        if_req = 1'b1; if_addr = 32'h100;
        @(posedge clk); #1;
        if_req = 1'b0;
        rdy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (if_valid !== 1'b1 || if_data !== 32'h13) begin
                n_fail++;
                $display("FAIL rdy_freeze %0d: v=%b d=%h required v=1 d=00000013", i, if_valid, if_data);
            end
            if (i < 3) begin
                @(posedge clk); #1;
            end
        end
        rdy = 1'b1;
        @(posedge clk); #1;
        n_tests++;
        if (if_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rdy_resume: if_valid=%b required 0", if_valid);
        end
    endtask

    task automatic test_random();
        logic [31:0] a;
        for (int k = 0; k < 40; k++) begin
            ctrl_delay    = $urandom_range(0, 4);
            ctrl_busy_len = $urandom_range(1, 3);
            a = {11'($urandom_range(0, 1)), 1'b0, 10'($urandom_range(0, 3)),
                 6'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 2'b00};
            do_fetch(a, -1);
        end
        ctrl_delay = 2;
        ctrl_busy_len = 2;
    endtask

    initial begin
        test_reset();
        test_cold_miss();
        test_hit();
        test_conflict();
        test_ctrl_delay();
        test_flush();
        test_back_to_back();
        test_reset_mid_wait();
        test_rdy_freeze();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
